// File: rtl/sc_registerpoint.sv
// One-hot point position register driven by the point-control FSM.
// Produces the binary position, active-low boundary flags, a saturating move counter and a fault flag.
module sc_registerpoint #(
  parameter int DATAWIDTH     = 8,
  parameter int INIT_POSITION = 3,
  parameter int COUNTWIDTH    = 8
) (
  input  logic                         SC_STATEMACHINEPOINT_CLOCK_50,
  input  logic                         SC_STATEMACHINEPOINT_RESET_InHigh,
  input  logic                         load_InLow,
  input  logic [1:0]                   shiftselection_In,
  output logic [DATAWIDTH-1:0]         point_Out,
  output logic [$clog2(DATAWIDTH)-1:0] position_Out,
  output logic                         atLeft_OutLow,
  output logic                         atRight_OutLow,
  output logic [COUNTWIDTH-1:0]        moveCount_Out,
  output logic                         movePulse_Out,
  output logic                         fault_Out
);

  localparam int POSW = $clog2(DATAWIDTH);
  localparam logic [DATAWIDTH-1:0] INIT_POINT = DATAWIDTH'(1) << INIT_POSITION;
  localparam logic [POSW-1:0]      INIT_POS   = POSW'(INIT_POSITION);
  localparam logic                 INIT_LEFT  = (INIT_POSITION != DATAWIDTH - 1);
  localparam logic                 INIT_RIGHT = (INIT_POSITION != 0);

  typedef enum logic [1:0] {
    CMD_LOAD  = 2'b00,
    CMD_LEFT  = 2'b01,
    CMD_RIGHT = 2'b10,
    CMD_HOLD  = 2'b11
  } cmd_t;

  cmd_t                  cmd;
  logic [DATAWIDTH-1:0]  point_reg, point_next;
  logic [POSW-1:0]       pos_reg, pos_next;
  logic                  left_reg, left_next;
  logic                  right_reg, right_next;
  logic [COUNTWIDTH-1:0] count_reg, count_next, count_sat;
  logic                  pulse_reg, pulse_next;
  logic                  fault_reg, fault_next;
  logic                  one_hot;

  assign cmd       = cmd_t'(shiftselection_In);
  assign one_hot   = (point_reg != '0) && ((point_reg & (point_reg - DATAWIDTH'(1))) == '0);
  assign count_sat = (count_reg == '1) ? count_reg : count_reg + COUNTWIDTH'(1);

  always_comb begin
    point_next = point_reg;
    count_next = count_reg;
    pulse_next = 1'b0;
    fault_next = fault_reg;
    if (!load_InLow || cmd == CMD_LOAD) begin
      point_next = INIT_POINT;
      count_next = '0;
      fault_next = 1'b0;
    end else if (!one_hot) begin
      // Corrupted register: recover to the home position and latch the fault
      point_next = INIT_POINT;
      fault_next = 1'b1;
    end else begin
      case (cmd)
        CMD_LEFT: if (!point_reg[DATAWIDTH-1]) begin
          point_next = point_reg << 1;
          count_next = count_sat;
          pulse_next = 1'b1;
        end
        CMD_RIGHT: if (!point_reg[0]) begin
          point_next = point_reg >> 1;
          count_next = count_sat;
          pulse_next = 1'b1;
        end
        default: ;
      endcase
    end

    // Derived outputs track the next point value so they land in the same cycle
    pos_next = '0;
    for (int i = DATAWIDTH - 1; i >= 0; i--) begin
      if (point_next[i]) pos_next = POSW'(i);
    end
    left_next  = ~point_next[DATAWIDTH-1];
    right_next = ~point_next[0];
  end

  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
      point_reg <= INIT_POINT;
      pos_reg   <= INIT_POS;
      left_reg  <= INIT_LEFT;
      right_reg <= INIT_RIGHT;
      count_reg <= '0;
      pulse_reg <= 1'b0;
      fault_reg <= 1'b0;
    end else begin
      point_reg <= point_next;
      pos_reg   <= pos_next;
      left_reg  <= left_next;
      right_reg <= right_next;
      count_reg <= count_next;
      pulse_reg <= pulse_next;
      fault_reg <= fault_next;
    end
  end

  assign point_Out      = point_reg;
  assign position_Out   = pos_reg;
  assign atLeft_OutLow  = left_reg;
  assign atRight_OutLow = right_reg;
  assign moveCount_Out  = count_reg;
  assign movePulse_Out  = pulse_reg;
  assign fault_Out      = fault_reg;

endmodule

// File: tb/tb_sc_registerpoint.sv
// Directed testbench for sc_registerpoint with default parameters (8-bit point, home index 3, 8-bit counter).
module tb_sc_registerpoint;

  logic       clk;
  logic       rst;
  logic       load_n;
  logic [1:0] sel;
  logic [7:0] point;
  logic [2:0] pos;
  logic       left_n;
  logic       right_n;
  logic [7:0] count;
  logic       pulse;
  logic       fault;

  int total = 0;
  int bad   = 0;

  sc_registerpoint dut (
    .SC_STATEMACHINEPOINT_CLOCK_50     (clk),
    .SC_STATEMACHINEPOINT_RESET_InHigh (rst),
    .load_InLow                        (load_n),
    .shiftselection_In                 (sel),
    .point_Out                         (point),
    .position_Out                      (pos),
    .atLeft_OutLow                     (left_n),
    .atRight_OutLow                    (right_n),
    .moveCount_Out                     (count),
    .movePulse_Out                     (pulse),
    .fault_Out                         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; load_n = 1'b1; sel = 2'b11;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (point !== 8'h08) begin bad++; $display("FAIL reset_point: got %h want %h", point, 8'h08); end
    total++; if (pos !== 3'd3) begin bad++; $display("FAIL reset_pos: got %0d want 3", pos); end
    total++; if (left_n !== 1'b1) begin bad++; $display("FAIL reset_left: got %b want 1", left_n); end
    total++; if (right_n !== 1'b1) begin bad++; $display("FAIL reset_right: got %b want 1", right_n); end
    total++; if (count !== 8'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse: got %b want 0", pulse); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %b want 0", fault); end
    $display("test_reset: point=%h pos=%0d count=%0d", point, pos, count);
  endtask

  task automatic test_shift_left();
    logic [7:0] exp_point;
    do_reset();
    exp_point = 8'h08;
    for (int k = 0; k < 4; k++) begin
      sel = 2'b01; step();
      exp_point = exp_point << 1;
      total++; if (pulse !== 1'b1) begin bad++; $display("FAIL left_pulse%0d: got %b want 1", k, pulse); end
      total++; if (point !== exp_point) begin bad++; $display("FAIL left_point%0d: got %h want %h", k, point, exp_point); end
      sel = 2'b11; step();
      total++; if (pulse !== 1'b0) begin bad++; $display("FAIL left_hold_pulse%0d: got %b want 0", k, pulse); end
      total++; if (point !== exp_point) begin bad++; $display("FAIL left_hold_point%0d: got %h want %h", k, point, exp_point); end
    end
    total++; if (pos !== 3'd7) begin bad++; $display("FAIL left_pos: got %0d want 7", pos); end
    total++; if (left_n !== 1'b0) begin bad++; $display("FAIL left_flag: got %b want 0", left_n); end
    total++; if (right_n !== 1'b1) begin bad++; $display("FAIL left_rflag: got %b want 1", right_n); end
    total++; if (count !== 8'd4) begin bad++; $display("FAIL left_count: got %0d want 4", count); end
    sel = 2'b01; step();
    total++; if (point !== 8'h80) begin bad++; $display("FAIL left_blocked_point: got %h want 80", point); end
    total++; if (pulse !== 1'b0) begin bad++; $display("FAIL left_blocked_pulse: got %b want 0", pulse); end
    total++; if (count !== 8'd4) begin bad++; $display("FAIL left_blocked_count: got %0d want 4", count); end
    sel = 2'b11;
    $display("test_shift_left: point=%h pos=%0d count=%0d", point, pos, count);
  endtask

  task automatic test_shift_right_held();
    logic [7:0] exp_point;
    int pulses;
    do_reset();
    exp_point = 8'h08;
    pulses = 0;
    sel = 2'b10;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k <= 3) exp_point = exp_point >> 1;
      if (pulse === 1'b1) pulses++;
      total++; if (point !== exp_point) begin bad++; $display("FAIL right_point%0d: got %h want %h", k, point, exp_point); end
      total++; if (pulse !== (k <= 3)) begin bad++; $display("FAIL right_pulse%0d: got %b want %b", k, pulse, (k <= 3)); end
    end
    sel = 2'b11;
    total++; if (pulses != 3) begin bad++; $display("FAIL right_pulses: got %0d want 3", pulses); end
    total++; if (count !== 8'd3) begin bad++; $display("FAIL right_count: got %0d want 3", count); end
    total++; if (right_n !== 1'b0) begin bad++; $display("FAIL right_flag: got %b want 0", right_n); end
    total++; if (pos !== 3'd0) begin bad++; $display("FAIL right_pos: got %0d want 0", pos); end
    $display("test_shift_right_held: point=%h count=%0d pulses=%0d", point, count, pulses);
  endtask

  task automatic test_load_priority();
    load_n = 1'b0; sel = 2'b01; step();
    load_n = 1'b1; sel = 2'b11;
    total++; if (point !== 8'h08) begin bad++; $display("FAIL load_point: got %h want 08", point); end
    total++; if (count !== 8'd0) begin bad++; $display("FAIL load_count: got %0d want 0", count); end
    total++; if (pulse !== 1'b0) begin bad++; $display("FAIL load_pulse: got %b want 0", pulse); end
    sel = 2'b01; step();
    sel = 2'b00; step();
    total++; if (point !== 8'h08) begin bad++; $display("FAIL sel00_point: got %h want 08", point); end
    total++; if (count !== 8'd0) begin bad++; $display("FAIL sel00_count: got %0d want 0", count); end
    sel = 2'b11;
    $display("test_load_priority: point=%h count=%0d", point, count);
  endtask

  task automatic test_fault();
    sel = 2'b11;
    force dut.point_reg = 8'h18;
    #1;
    release dut.point_reg;
    step();
    total++; if (point !== 8'h08) begin bad++; $display("FAIL fault_point: got %h want 08", point); end
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL fault_set: got %b want 1", fault); end
    sel = 2'b01; step();
    total++; if (point !== 8'h10) begin bad++; $display("FAIL fault_shift_point: got %h want 10", point); end
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL fault_sticky: got %b want 1", fault); end
    sel = 2'b11; step();
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL fault_hold: got %b want 1", fault); end
    load_n = 1'b0; step();
    load_n = 1'b1;
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL fault_clear: got %b want 0", fault); end
    $display("test_fault: point=%h fault=%b", point, fault);
  endtask

  task automatic test_async_reset();
    sel = 2'b10; step(); step();
    total++; if (point !== 8'h02) begin bad++; $display("FAIL async_pre_point: got %h want 02", point); end
    #2 rst = 1'b1;
    #1;
    total++; if (point !== 8'h08) begin bad++; $display("FAIL async_point: got %h want 08", point); end
    total++; if (count !== 8'd0) begin bad++; $display("FAIL async_count: got %0d want 0", count); end
    total++; if (pos !== 3'd3) begin bad++; $display("FAIL async_pos: got %0d want 3", pos); end
    total++; if (pulse !== 1'b0) begin bad++; $display("FAIL async_pulse: got %b want 0", pulse); end
    #1 rst = 1'b0;
    sel = 2'b11;
    step();
    $display("test_async_reset: point=%h count=%0d", point, count);
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 1; k <= 300; k++) begin
      sel = (k % 2 == 1) ? 2'b01 : 2'b10;
      step();
      if (k == 254) begin
        total++; if (count !== 8'd254) begin bad++; $display("FAIL sat_count254: got %0d want 254", count); end
      end
      if (k == 256) begin
        total++; if (count !== 8'd255) begin bad++; $display("FAIL sat_count256: got %0d want 255", count); end
      end
    end
    sel = 2'b11;
    total++; if (count !== 8'd255) begin bad++; $display("FAIL sat_count: got %0d want 255", count); end
    total++; if (point !== 8'h08) begin bad++; $display("FAIL sat_point: got %h want 08", point); end
    total++; if (pulse !== 1'b1) begin bad++; $display("FAIL sat_pulse: got %b want 1", pulse); end
    $display("test_saturation: count=%0d point=%h", count, point);
  endtask

  initial begin
    rst = 1'b1; load_n = 1'b1; sel = 2'b11;
    test_reset();
    test_shift_left();
    test_shift_right_held();
    test_load_priority();
    test_fault();
    test_async_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sc_registerpoint.md
Name: sc_registerpoint

Overview:
- Downstream datapath stage of the point-control state machine.
- Consumes the FSM's 2-bit shift-selection code and active-low load strobe.
- Holds a one-hot "point" position register. Produces the position in binary, active-low boundary flags (fed back to the FSM as its move-permission comparator inputs) and a move counter for display.
- All state is registered; outputs are driven directly from flops.

Parameters:
- DATAWIDTH, 8, width of the one-hot point register; legal range 4..16.
- INIT_POSITION, 3, bit index set on load and reset; legal range 0..DATAWIDTH-1.
- COUNTWIDTH, 8, width of the saturating move counter.

Ports:
- SC_STATEMACHINEPOINT_CLOCK_50  in  1  system clock, rising edge
- SC_STATEMACHINEPOINT_RESET_InHigh  in  1  asynchronous, active-high reset
- load_InLow  in  1  active-low load strobe from the FSM
- shiftselection_In  in  2  00 load, 01 shift left, 10 shift right, 11 hold
- point_Out  out  DATAWIDTH  one-hot point register
- position_Out  out  clog2(DATAWIDTH)  binary index of the set bit
- atLeft_OutLow  out  1  0 when the point is at the MSB, i.e. a left shift is blocked
- atRight_OutLow  out  1  0 when the point is at the LSB, i.e. a right shift is blocked
- moveCount_Out  out  COUNTWIDTH  count of accepted shifts since the last load or reset, saturating
- movePulse_Out  out  1  1-cycle pulse, registered, one cycle after an accepted shift
- fault_Out  out  1  sticky; set when the register was found not one-hot

Behaviour:
- Reset: SC_STATEMACHINEPOINT_RESET_InHigh, asynchronous, active-high; clock SC_STATEMACHINEPOINT_CLOCK_50.
- Reset values:
  - point_Out = 1<<INIT_POSITION; position_Out = INIT_POSITION.
  - atLeft_OutLow and atRight_OutLow are computed from INIT_POSITION.
  - moveCount_Out = 0; movePulse_Out = 0; fault_Out = 0.
- Reset asserted mid-operation overrides everything immediately, with no clock needed.
- Command priority, evaluated each rising edge:
  1. load_InLow = 0.
  2. shiftselection_In = 00.
  3. Shift left or shift right.
  4. Hold.
- Load (1 or 2):
  - point_Out <= 1<<INIT_POSITION; moveCount_Out <= 0; movePulse_Out <= 0.
  - fault_Out <= 0. Load is the only non-reset clear of fault_Out.
- Shift left (01):
  - Accepted only if point_Out[DATAWIDTH-1] = 0; then point_Out <= point_Out<<1.
  - Blocked at the MSB: register is unchanged, no pulse, no count. There is no wrap-around.
- Shift right (10):
  - Accepted only if point_Out[0] = 0; then point_Out <= point_Out>>1.
  - Blocked at the LSB: same as a blocked left shift.
- Hold (11): all registers keep their values; movePulse_Out <= 0.
- Accepted shift: movePulse_Out <= 1 for exactly one cycle. moveCount_Out increments and saturates at all-ones.
- Continuous commands: a shift held for N cycles moves up to N positions, stopping at the boundary. Edge-detection is the FSM's job; the FSM issues a shift for one cycle only.
- Derived outputs:
  - position_Out, atLeft_OutLow and atRight_OutLow are registered alongside point_Out, consistent with it in the same cycle.
  - Latency from command edge to updated outputs is 1 clock.
- Integrity check, every edge that is not a load:
  - If point_Out has zero bits or more than one bit set, point_Out <= 1<<INIT_POSITION and fault_Out <= 1.
  - The check overrides shift and hold that edge.
- Width rules:
  - Shifts are logical and zero-fill.
  - position_Out is the index of the set bit; the encoder uses a priority search from the LSB.

Test Plan:
- Reset with defaults -> point_Out = 8'b00001000, position_Out = 3, atLeft_OutLow = 1, atRight_OutLow = 1, moveCount_Out = 0, fault_Out = 0.
- Four single-cycle 01 commands separated by 11 -> point_Out = 8'b10000000, position 7, atLeft_OutLow = 0, moveCount_Out = 4, four movePulse_Out pulses. A fifth 01 -> no change, no pulse, count stays 4.
- From reset, 10 held for 5 cycles -> point_Out = 8'b00000001 after 3 cycles, then stays there; atRight_OutLow = 0; moveCount_Out = 3; exactly 3 pulses.
- After moves, assert load_InLow = 0 with shiftselection_In = 01 in the same cycle -> load wins: point_Out = 8'b00001000, moveCount_Out = 0, no pulse.
- Force point_Out to 8'b00011000 -> next edge gives point_Out = 8'b00001000 and fault_Out = 1. fault_Out stays 1 through shifts and clears only on load.
- Assert reset mid-shift, asynchronously between edges -> outputs return to reset values immediately. Run 300 accepted alternating shifts -> moveCount_Out saturates at 255.
